// File: rtl/vce_pkg.sv
// rtl/vce_pkg.sv - shared types, defaults and helpers for the vector check engine
package vce_pkg;

  localparam int         KEY_W_DEF     = 3;
  localparam logic [2:0] KEY_VALUE_DEF = 3'b111;
  localparam int         SAT_W         = 64;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_CHECK = 6'b000010,
    S_FETCH = 6'b000100,
    S_LATCH = 6'b001000,
    S_WAIT  = 6'b010000,
    S_LOCK  = 6'b100000
  } state_t;

  // Increment-by-inc that sticks at the all-ones value of a width-bit counter (width <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic             inc,
                                               input int               width);
    logic [SAT_W-1:0] max_val;
    max_val = (width >= SAT_W) ? {SAT_W{1'b1}} : ((64'd1 << width) - 64'd1);
    if (inc && (value != max_val)) begin
      return value + 64'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/vce_compare_acc.sv
// rtl/vce_compare_acc.sv - result compare, saturating mismatch counter, first-fail capture
module vce_compare_acc
  import vce_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] expected,
  input  logic [ADDR_W-1:0] index,
  output logic [CNT_W-1:0]  count,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_idx
);

  logic mismatch;

  assign mismatch = (result != expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else if (clear) begin
      count      <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else if (en) begin
      count <= CNT_W'(sat_inc(SAT_W'(count), mismatch, CNT_W));
      // Only the first failing index of a run is kept.
      if (mismatch && !fail_valid) begin
        fail_idx   <= index;
        fail_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_check_engine.sv
// rtl/vector_check_engine.sv - key-locked ROM vector walker driving an ap_-handshaked operator
module vector_check_engine
  import vce_pkg::*;
#(
  parameter int               DATA_W    = 64,
  parameter int               DEPTH     = 20,
  parameter int               ADDR_W    = 5,
  parameter int               CNT_W     = 32,
  parameter int               KEY_W     = 3,
  parameter logic [KEY_W-1:0] KEY_VALUE = KEY_W'(KEY_VALUE_DEF)
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [CNT_W-1:0]  ap_return,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              stop_on_fail,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [ADDR_W-1:0] rom_address0,
  output logic              rom_ce0,
  input  logic [DATA_W-1:0] a_q0,
  input  logic [DATA_W-1:0] b_q0,
  input  logic [DATA_W-1:0] z_q0,
  output logic              op_start,
  input  logic              op_ready,
  input  logic              op_done,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] op_result,
  input  logic [KEY_W-1:0]  working_key
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   index;
  logic [ADDR_W:0]   limit;
  logic              stop_latched;
  logic              start_reg;
  logic [DATA_W-1:0] expected;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              acc_en;
  logic              finish;
  logic              key_ok;

  assign key_ok = (working_key == KEY_VALUE);
  assign finish = (index == limit) || (stop_latched && fail_valid);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ap_done    = 1'b0;
    rom_ce0    = 1'b0;
    accept     = 1'b0;
    acc_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ap_start) begin
          if (key_ok) begin
            accept     = 1'b1;
            state_next = S_CHECK;
          end else begin
            state_next = S_LOCK;
          end
        end
      end
      S_CHECK: begin
        if (finish) begin
          ap_done    = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        rom_ce0    = 1'b1;
        state_next = S_LATCH;
      end
      S_LATCH: state_next = S_WAIT;
      S_WAIT: begin
        if (op_done) begin
          acc_en     = 1'b1;
          state_next = S_CHECK;
        end
      end
      S_LOCK:  state_next = S_LOCK;
      default: state_next = S_IDLE;
    endcase
  end

  assign ap_ready     = ap_done;
  assign ap_idle      = (state == S_IDLE) && !ap_start;
  assign ap_return    = count;
  assign rom_address0 = index[ADDR_W-1:0];
  assign op_start     = start_reg;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      index        <= '0;
      limit        <= '0;
      stop_latched <= 1'b0;
      start_reg    <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      expected     <= '0;
    end else begin
      if (accept) begin
        index        <= '0;
        limit        <= (num_vec > DEPTH_L) ? DEPTH_L : num_vec;
        stop_latched <= stop_on_fail;
      end
      if (acc_en) begin
        index <= index + 1'b1;
      end
      if (state == S_LATCH) begin
        op_a     <= a_q0;
        op_b     <= b_q0;
        expected <= z_q0;
      end
      // The start request stays up until the operator takes it, whatever the FSM is doing.
      if (state == S_LATCH) begin
        start_reg <= 1'b1;
      end else if (op_ready) begin
        start_reg <= 1'b0;
      end
    end
  end

  vce_compare_acc #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_compare_acc (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .clear     (accept),
    .en        (acc_en),
    .result    (op_result),
    .expected  (expected),
    .index     (index[ADDR_W-1:0]),
    .count     (count),
    .fail_valid(fail_valid),
    .fail_idx  (fail_idx)
  );

endmodule

// File: tb/tb_vector_check_engine.sv
// tb/tb_vector_check_engine.sv - directed self-checking bench for vector_check_engine
module tb_vector_check_engine;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 20;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 32;
  localparam int KEY_W  = 3;

  logic              ap_clk;
  logic              ap_rst;
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [CNT_W-1:0]  ap_return;
  logic [ADDR_W:0]   num_vec;
  logic              stop_on_fail;
  logic              fail_valid;
  logic [ADDR_W-1:0] fail_idx;
  logic [ADDR_W-1:0] rom_address0;
  logic              rom_ce0;
  logic [DATA_W-1:0] a_q0, b_q0, z_q0;
  logic              op_start;
  logic              op_ready;
  logic              op_done;
  logic [DATA_W-1:0] op_a, op_b, op_result;
  logic [KEY_W-1:0]  working_key;

  vector_check_engine #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .KEY_W(KEY_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_return(ap_return),
    .num_vec(num_vec), .stop_on_fail(stop_on_fail), .fail_valid(fail_valid),
    .fail_idx(fail_idx), .rom_address0(rom_address0), .rom_ce0(rom_ce0),
    .a_q0(a_q0), .b_q0(b_q0), .z_q0(z_q0), .op_start(op_start),
    .op_ready(op_ready), .op_done(op_done), .op_a(op_a), .op_b(op_b),
    .op_result(op_result), .working_key(working_key)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  logic [DATA_W-1:0] a_rom [DEPTH];
  logic [DATA_W-1:0] b_rom [DEPTH];
  logic [DATA_W-1:0] z_rom [DEPTH];

  always @(posedge ap_clk) begin
    if (rom_ce0) begin
      a_q0 <= a_rom[rom_address0];
      b_q0 <= b_rom[rom_address0];
      z_q0 <= z_rom[rom_address0];
    end
  end

  int ready_dly = 0;
  int done_dly  = 0;
  int start_pulses = 0;
  logic start_prev = 1'b0;

  always @(negedge ap_clk) begin
    if (op_start && !start_prev) start_pulses++;
    start_prev = op_start;
  end

  // Operator model: 64-bit integer multiply, inputs changed just after the rising edge.
  initial begin : op_model
    logic [DATA_W-1:0] ra, rb;
    op_ready = 1'b0; op_done = 1'b0; op_result = '0;
    forever begin
      @(posedge ap_clk); #1;
      op_ready = 1'b0; op_done = 1'b0;
      if (op_start) begin
        repeat (ready_dly) begin @(posedge ap_clk); #1; end
        op_ready = 1'b1; ra = op_a; rb = op_b;
        @(posedge ap_clk); #1;
        op_ready = 1'b0;
        repeat (done_dly) begin @(posedge ap_clk); #1; end
        op_done = 1'b1; op_result = ra * rb;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic run(input int nv, input logic sof, input int budget,
                     output int cyc, output logic seen);
    start_pulses = 0;
    @(negedge ap_clk);
    num_vec = 6'(nv); stop_on_fail = sof; ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    cyc = 2;
    while (!ap_done && cyc < budget) begin
      @(negedge ap_clk);
      cyc++;
    end
    seen = ap_done;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; ap_start = 1'b0; num_vec = '0; stop_on_fail = 1'b0; working_key = 3'b111;
    repeat (3) @(negedge ap_clk);
    n_vec++; if ({ap_idle, ap_done, ap_ready, fail_valid, op_start, rom_ce0} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_flags got %b want 100000", {ap_idle, ap_done, ap_ready, fail_valid, op_start, rom_ce0}); end
    n_vec++; if (ap_return !== 32'd0) begin n_bad++; $display("FAIL reset_return got %0d want 0", ap_return); end
    n_vec++; if ({op_a, op_b, 3'b000, fail_idx} !== '0) begin n_bad++; $display("FAIL reset_regs op_a %h op_b %h fail_idx %0d want 0", op_a, op_b, fail_idx); end
    ap_rst = 1'b0;
    @(negedge ap_clk);
  endtask

  task automatic test_pass_all();
    int cyc; logic seen;
    run(20, 1'b0, 400, cyc, seen);
    n_vec++; if (seen !== 1'b1 || ap_ready !== 1'b1) begin n_bad++; $display("FAIL pass_done got done %b ready %b want 1 1", seen, ap_ready); end
    n_vec++; if (cyc != 102) begin n_bad++; $display("FAIL pass_latency got %0d want 102", cyc); end
    n_vec++; if (ap_return !== 32'd0 || fail_valid !== 1'b0) begin n_bad++; $display("FAIL pass_result got %0d/%b want 0/0", ap_return, fail_valid); end
    n_vec++; if (start_pulses != 20) begin n_bad++; $display("FAIL pass_starts got %0d want 20", start_pulses); end
    @(negedge ap_clk);
    n_vec++; if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin n_bad++; $display("FAIL pass_pulse got done %b idle %b want 0 1", ap_done, ap_idle); end
  endtask

  task automatic test_corrupt();
    int cyc; logic seen;
    z_rom[3] = z_rom[3] ^ 64'h1;
    z_rom[7] = z_rom[7] ^ 64'h8000_0000_0000_0000;
    run(20, 1'b0, 400, cyc, seen);
    n_vec++; if (seen !== 1'b1 || cyc != 102) begin n_bad++; $display("FAIL corrupt_done got %b at %0d want 1 at 102", seen, cyc); end
    n_vec++; if (ap_return !== 32'd2) begin n_bad++; $display("FAIL corrupt_count got %0d want 2", ap_return); end
    n_vec++; if (fail_valid !== 1'b1 || fail_idx !== 5'd3) begin n_bad++; $display("FAIL corrupt_first got %b/%0d want 1/3", fail_valid, fail_idx); end
    n_vec++; if (start_pulses != 20) begin n_bad++; $display("FAIL corrupt_starts got %0d want 20", start_pulses); end
    repeat (5) @(negedge ap_clk);
    n_vec++; if (ap_return !== 32'd2 || fail_idx !== 5'd3) begin n_bad++; $display("FAIL corrupt_hold got %0d/%0d want 2/3", ap_return, fail_idx); end
  endtask

  task automatic test_stop_on_fail();
    int cyc; logic seen;
    run(20, 1'b1, 400, cyc, seen);
    n_vec++; if (seen !== 1'b1 || cyc != 22) begin n_bad++; $display("FAIL stop_done got %b at %0d want 1 at 22", seen, cyc); end
    n_vec++; if (ap_return !== 32'd1 || fail_idx !== 5'd3) begin n_bad++; $display("FAIL stop_result got %0d/%0d want 1/3", ap_return, fail_idx); end
    n_vec++; if (start_pulses != 4) begin n_bad++; $display("FAIL stop_starts got %0d want 4", start_pulses); end
  endtask

  task automatic test_num_vec();
    int cyc; logic seen;
    run(0, 1'b0, 50, cyc, seen);
    n_vec++; if (seen !== 1'b1 || cyc != 2) begin n_bad++; $display("FAIL nv0_done got %b at %0d want 1 at 2", seen, cyc); end
    n_vec++; if (ap_return !== 32'd0 || fail_valid !== 1'b0 || start_pulses != 0) begin
      n_bad++; $display("FAIL nv0_result got %0d/%b/%0d want 0/0/0", ap_return, fail_valid, start_pulses); end
    run(31, 1'b0, 400, cyc, seen);
    n_vec++; if (seen !== 1'b1 || cyc != 102 || start_pulses != 20) begin
      n_bad++; $display("FAIL nv31_clamp got %b at %0d with %0d starts want 1 at 102 with 20", seen, cyc, start_pulses); end
    n_vec++; if (ap_return !== 32'd2) begin n_bad++; $display("FAIL nv31_count got %0d want 2", ap_return); end
  endtask

  task automatic test_slow_op_reset();
    logic [DATA_W-1:0] saved;
    int hold; int guard;
    saved = z_rom[0];
    z_rom[0] = z_rom[0] + 64'd1;
    ready_dly = 5; done_dly = 10;
    @(negedge ap_clk);
    num_vec = 6'd2; stop_on_fail = 1'b0; ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    guard = 0;
    while (!op_start && guard < 20) begin @(negedge ap_clk); guard++; end
    hold = 0;
    while (op_start && !op_ready && hold < 50) begin hold++; @(negedge ap_clk); end
    n_vec++; if (hold != 5) begin n_bad++; $display("FAIL slow_hold got %0d want 5", hold); end
    @(negedge ap_clk);
    n_vec++; if (op_start !== 1'b0) begin n_bad++; $display("FAIL slow_release got %b want 0", op_start); end
    guard = 0;
    while (!op_start && guard < 40) begin @(negedge ap_clk); guard++; end
    n_vec++; if (op_start !== 1'b1 || ap_return !== 32'd1 || fail_valid !== 1'b1) begin
      n_bad++; $display("FAIL slow_second got start %b count %0d fv %b want 1 1 1", op_start, ap_return, fail_valid); end
    ap_rst = 1'b1;
    #1;
    n_vec++; if (op_start !== 1'b0) begin n_bad++; $display("FAIL async_drop got %b want 0", op_start); end
    @(negedge ap_clk);
    n_vec++; if ({ap_idle, ap_done, ap_ready, fail_valid, op_start, rom_ce0} !== 6'b100000 ||
                 ap_return !== 32'd0 || fail_idx !== 5'd0 || op_a !== '0 || op_b !== '0) begin
      n_bad++; $display("FAIL midrun_reset got flags %b ret %0d idx %0d a %h b %h want 100000 0 0 0 0",
                        {ap_idle, ap_done, ap_ready, fail_valid, op_start, rom_ce0}, ap_return, fail_idx, op_a, op_b); end
    ap_rst = 1'b0;
    repeat (30) @(negedge ap_clk);
    ready_dly = 0; done_dly = 0;
    z_rom[0] = saved;
  endtask

  task automatic test_lock();
    int cyc; logic seen; int done_cnt; int idle_cnt; int act_cnt;
    done_cnt = 0; idle_cnt = 0; act_cnt = 0;
    @(negedge ap_clk);
    working_key = 3'b101; num_vec = 6'd20; ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (ap_done) done_cnt++;
      if (ap_idle) idle_cnt++;
      if (op_start || rom_ce0) act_cnt++;
      @(negedge ap_clk);
    end
    n_vec++; if (done_cnt != 0) begin n_bad++; $display("FAIL lock_done got %0d cycles want 0", done_cnt); end
    n_vec++; if (idle_cnt != 0 || act_cnt != 0) begin n_bad++; $display("FAIL lock_quiet got idle %0d active %0d want 0 0", idle_cnt, act_cnt); end
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0; working_key = 3'b111;
    @(negedge ap_clk);
    n_vec++; if (ap_idle !== 1'b1) begin n_bad++; $display("FAIL lock_reset_idle got %b want 1", ap_idle); end
    run(2, 1'b0, 100, cyc, seen);
    n_vec++; if (seen !== 1'b1 || cyc != 12 || ap_return !== 32'd0) begin
      n_bad++; $display("FAIL lock_recover got %b at %0d ret %0d want 1 at 12 ret 0", seen, cyc, ap_return); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      a_rom[i] = 64'h0123_4567_0000_0000 + 64'(i * 977 + 5);
      b_rom[i] = 64'h0000_0001_0000_0000 | 64'(i * 31 + 7);
      z_rom[i] = a_rom[i] * b_rom[i];
    end
    test_reset();
    test_pass_all();
    test_corrupt();
    test_stop_on_fail();
    test_num_vec();
    test_slow_op_reset();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_check_engine.md
Name: vector_check_engine

Overview:
Parametrised self-check harness that walks a ROM of operand/expected-result vectors and drives an external ap_-handshaked arithmetic operator (float64_mul or any DATA_W-wide two-operand core). It compares each operator result against the expected value and counts mismatches. It also records the first failing index and supports a stop-on-first-fail mode and a runtime vector count. Key-locked: the FSM runs only under the correct working_key.

Parameters:
DATA_W, 64, operand/result width
DEPTH, 20, vectors stored in each ROM
ADDR_W, 5, ROM address width (2^ADDR_W >= DEPTH)
CNT_W, 32, mismatch counter / ap_return width
KEY_W, 3, working_key width
KEY_VALUE, 3'b111 (KEY_W bits), unlocking key

Ports:
ap_clk  in  1  clock
ap_rst  in  1  reset, asynchronous, active-high
ap_start  in  1  run request
ap_done  out  1  run complete (1-cycle pulse)
ap_idle  out  1  idle and no request
ap_ready  out  1  equals ap_done
ap_return  out  CNT_W  mismatch count of last run
num_vec  in  ADDR_W+1  vectors to check, sampled at start; clamped to DEPTH
stop_on_fail  in  1  end run at first mismatch, sampled at start
fail_valid  out  1  at least one mismatch in last run
fail_idx  out  ADDR_W  index of first mismatch
rom_address0  out  ADDR_W  shared address to a/b/z ROMs
rom_ce0  out  1  ROM read enable
a_q0, b_q0, z_q0  in  DATA_W each  ROM data, 1-cycle read latency
op_start  out  1  operator start
op_ready  in  1  operator accepted start
op_done  in  1  operator result valid
op_a, op_b  out  DATA_W each  registered operands
op_result  in  DATA_W  operator result
working_key  in  KEY_W  lock key

Behaviour:
- Reset (async): FSM=IDLE; ap_return=0; fail_valid=0; fail_idx=0; op_start=0; op_a/op_b=0; index=0. ap_done=ap_ready=0. ap_idle follows the IDLE rule below.
- States (one-hot): IDLE, CHECK, FETCH, LATCH, WAIT, LOCK.
- IDLE:
  - ap_idle=1 while ap_start=0.
  - On ap_start=1:
    - If working_key==KEY_VALUE: index<=0, count<=0, fail_valid<=0, fail_idx<=0, latch min(num_vec,DEPTH) and stop_on_fail; go to CHECK.
    - Otherwise go to LOCK.
- CHECK:
  - Exit when index==limit, or when stop_on_fail=1 and fail_valid=1.
  - On exit: ap_done=ap_ready=1 combinationally for this one cycle, then go to IDLE.
  - Otherwise go to FETCH.
  - num_vec=0: exits on the first CHECK cycle with ap_return=0.
- FETCH: rom_ce0=1, rom_address0=index; go to LATCH.
- LATCH: op_a<=a_q0, op_b<=b_q0, exp<=z_q0; set start_reg<=1; go to WAIT.
- op_start=start_reg. start_reg clears on the cycle op_ready=1 is sampled, regardless of state.
- WAIT: stay until op_done=1. On that cycle:
  - mismatch = (op_result != exp).
  - count <= count + mismatch, saturating at 2^CNT_W-1.
  - If mismatch and !fail_valid: fail_idx<=index, fail_valid<=1.
  - index<=index+1; go to CHECK.
- Per-vector latency: 3 cycles + operator latency (op_done no earlier than the cycle after op_ready).
- ap_return, fail_valid and fail_idx hold their values between runs; they clear only at the next accepted start or at reset.
- LOCK: terminal. ap_idle=0, ap_done=0, op_start=0, rom_ce0=0. Leaves only on ap_rst.
- ap_start during a run is ignored. ap_rst mid-run aborts immediately; op_start drops asynchronously.
- Simultaneous op_ready and op_done in the same cycle are legal; both take effect.

Decomposition:
- Shared package vce_pkg: state encoding localparams, KEY_VALUE default, saturating-add function.
- One natural sub-module: vce_compare_acc (mismatch compare, saturating counter, first-fail capture), instantiated once.

Test Plan:
- Correct key, num_vec=20, operator model returns z for all vectors -> ap_done after 20 vectors, ap_return=0, fail_valid=0.
- Vectors 3 and 7 corrupted, stop_on_fail=0 -> ap_return=2, fail_idx=3, fail_valid=1, all 20 vectors issued.
- Same vectors, stop_on_fail=1 -> ap_done after the 4th op_done, ap_return=1, fail_idx=3, exactly 4 op_start pulses.
- working_key=3'b101 -> FSM in LOCK, ap_done never asserts over 1000 cycles, ap_idle=0; ap_rst returns to IDLE with ap_idle=1.
- num_vec=0, then num_vec=31 -> first: ap_done 2 cycles after start, ap_return=0; second: clamped to 20 vectors.
- Operator holds op_ready low 5 cycles, op_done 10 cycles later; ap_rst asserted mid-WAIT -> op_start held high until op_ready; after reset, all outputs at reset values.
